// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SAD tracker.
//   PIX_W    : pixel width
//   SAD_W    : accumulator / SAD width (256 * 255 = 65280 fits without wrap)
//   IDX_W    : candidate index width (32 candidates per search)
//   SAD_INIT : running-minimum start value, above any reachable SAD
//   state_t  : tracker FSM encoding
//   abs_diff : unsigned magnitude of the difference of two pixels
package me_pkg;

    localparam int PIX_W = 8;
    localparam int SAD_W = 16;
    localparam int IDX_W = 5;

    localparam logic [SAD_W-1:0] SAD_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad_min_tracker_if.sv
// Pixel-stream / result bundle between the search-window controller and
// the SAD tracker.
//
// Handshake: there is no backpressure. `start` is a one-cycle pulse that
// opens (or restarts) a search; `c`/`p`/`p_prime` carry one valid pixel
// per cycle while the tracker is accumulating and are ignored otherwise.
// `done` is a one-cycle pulse and `best_sad`/`best_idx` are valid on it.
//
//   start, c, p, p_prime       : controller -> tracker
//   busy, done, best_sad,
//   best_idx, dbg_state        : tracker -> controller / result register
interface sad_min_tracker_if;
    import me_pkg::*;

    logic               start;
    logic [PIX_W-1:0]   c;
    logic [PIX_W-1:0]   p;
    logic [PIX_W-1:0]   p_prime;
    logic               busy;
    logic               done;
    logic [SAD_W-1:0]   best_sad;
    logic [IDX_W-1:0]   best_idx;
    state_t             dbg_state;

    modport master (
        output start, c, p, p_prime,
        input  busy, done, best_sad, best_idx, dbg_state
    );

    modport slave (
        input  start, c, p, p_prime,
        output busy, done, best_sad, best_idx, dbg_state
    );

endinterface

// File: rtl/absdiff_acc.sv
// One SAD lane: absolute difference of two pixels accumulated into a
// 16-bit register. sum_o is the combinational running total including the
// current pixel, so the owner can compare the finished SAD on the last
// pixel of a candidate while the register clears on that same edge.
//
//   clk, reset : clock, synchronous active-low reset
//   en_i       : accumulate this cycle
//   clr_i      : clear the accumulator (wins over en_i)
//   a_i, b_i   : pixels to difference
//   sum_o      : accumulator + |a_i - b_i|
module absdiff_acc
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PIX_W-1:0]   a_i,
    input  logic [PIX_W-1:0]   b_i,
    output logic [SAD_W-1:0]   sum_o
);

    logic [SAD_W-1:0] acc_q;
    logic [SAD_W-1:0] acc_d;
    logic [PIX_W-1:0] diff;

    always_comb begin
        diff  = abs_diff(a_i, b_i);
        sum_o = acc_q + {{(SAD_W-PIX_W){1'b0}}, diff};
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// SAD minimum tracker. After a `start` pulse it waits LEAD_CYCLES cycles,
// then accumulates NUM_PAIRS * PIX_PER_CAND pixels, computing the SAD of two
// candidates per pair (even from p, odd from p_prime), and keeps the lowest
// SAD and its candidate index. The result is published with a one-cycle
// `done`. A `start` at any time (re)opens a search.
//
//   clk, reset : clock, synchronous active-low reset
//   bus        : sad_min_tracker_if.slave (start/pixels in, status/result out)
//
// PIX_PER_CAND and NUM_PAIRS are expected to be powers of two so the pixel
// counter splits cleanly into {pair, pixel-in-pair}; LEAD_CYCLES >= 1.
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int LEAD_CYCLES  = 16,
    parameter int PIX_PER_CAND = 256,
    parameter int NUM_PAIRS    = 16
) (
    input  logic             clk,
    input  logic             reset,
    sad_min_tracker_if.slave bus
);

    localparam int PIX_BITS  = $clog2(PIX_PER_CAND);
    localparam int PAIR_BITS = $clog2(NUM_PAIRS);
    localparam int CNT_W     = PIX_BITS + PAIR_BITS;
    localparam int LEAD_W    = $clog2(LEAD_CYCLES + 1);

    localparam logic [LEAD_W-1:0]    LEAD_LAST = LEAD_W'(LEAD_CYCLES - 1);
    localparam logic [PIX_BITS-1:0]  PIX_LAST  = PIX_BITS'(PIX_PER_CAND - 1);
    localparam logic [PAIR_BITS-1:0] PAIR_LAST = PAIR_BITS'(NUM_PAIRS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [LEAD_W-1:0]  lead_cnt_q, lead_cnt_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [SAD_W-1:0]   min_q,      min_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;

    logic [PIX_BITS-1:0]  pix_in_pair;
    logic [PAIR_BITS-1:0] pair_k;
    logic                 accum;
    logic                 pair_end;
    logic                 search_end;
    logic [IDX_W-1:0]     idx_even;
    logic [IDX_W-1:0]     idx_odd;

    logic [SAD_W-1:0]     sum_a;
    logic [SAD_W-1:0]     sum_b;
    logic [SAD_W-1:0]     min_a, min_b;
    logic [IDX_W-1:0]     idx_a, idx_b;

    always_comb begin
        pix_in_pair = cnt_q[PIX_BITS-1:0];
        pair_k      = cnt_q[CNT_W-1:PIX_BITS];
        accum       = (state_q == ACCUM);
        pair_end    = accum && (pix_in_pair == PIX_LAST);
        search_end  = pair_end && (pair_k == PAIR_LAST);
        idx_even    = IDX_W'({pair_k, 1'b0});
        idx_odd     = IDX_W'({pair_k, 1'b1});
    end

    // ------------------------------------------------------------------
    // Two accumulation lanes. They clear on a new search and at the end
    // of every pair, on the same edge the finished sums are compared.
    // ------------------------------------------------------------------
    absdiff_acc u_lane_a (
        .clk   (clk),
        .reset (reset),
        .en_i  (accum),
        .clr_i (bus.start || pair_end),
        .a_i   (bus.p),
        .b_i   (bus.c),
        .sum_o (sum_a)
    );

    absdiff_acc u_lane_b (
        .clk   (clk),
        .reset (reset),
        .en_i  (accum),
        .clr_i (bus.start || pair_end),
        .a_i   (bus.p_prime),
        .b_i   (bus.c),
        .sum_o (sum_b)
    );

    // Even candidate is compared first, odd candidate against the result,
    // strict less-than so a tie keeps the lower index.
    always_comb begin
        min_a = min_q;
        idx_a = idx_q;
        if (sum_a < min_a) begin
            min_a = sum_a;
            idx_a = idx_even;
        end
        min_b = min_a;
        idx_b = idx_a;
        if (sum_b < min_b) begin
            min_b = sum_b;
            idx_b = idx_odd;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. start is accepted in every state and always
    // (re)enters LEAD, which makes aborts and back-to-back searches uniform.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = LEAD;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                LEAD:    if (lead_cnt_q == LEAD_LAST) state_d = ACCUM;
                ACCUM:   if (search_end) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy      = (state_q == LEAD) || (state_q == ACCUM);
        bus.done      = (state_q == DONE);
        bus.best_sad  = best_sad_q;
        bus.best_idx  = best_idx_q;
        bus.dbg_state = state_q;
    end

    // ------------------------------------------------------------------
    // Counters and min tracking
    // ------------------------------------------------------------------
    always_comb begin
        lead_cnt_d = lead_cnt_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        idx_d      = idx_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;

        if (bus.start) begin
            lead_cnt_d = '0;
            cnt_d      = '0;
            min_d      = SAD_INIT;
            idx_d      = '0;
        end else begin
            if (state_q == LEAD) begin
                lead_cnt_d = lead_cnt_q + LEAD_W'(1);
            end
            if (accum) begin
                // Wraps to 0 after the last pixel of the search.
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (pair_end) begin
                min_d = min_b;
                idx_d = idx_b;
            end
            // Results are only published at the end of a full search,
            // so intermediate minima never reach the outputs.
            if (search_end) begin
                best_sad_d = min_b;
                best_idx_d = idx_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lead_cnt_q <= '0;
            cnt_q      <= '0;
            min_q      <= '0;
            idx_q      <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
        end else begin
            lead_cnt_q <= lead_cnt_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            idx_q      <= idx_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

endmodule

// File: tb/tb_sad_min_tracker.sv
module tb_sad_min_tracker;
    import me_pkg::*;

    localparam int LEAD   = 16;
    localparam int PPC    = 256;
    localparam int NPAIR  = 16;
    localparam int NPIX   = PPC * NPAIR;
    localparam int NCAND  = 2 * NPAIR;
    localparam int DONE_LAT = 1 + LEAD + NPIX;  // start cycle -> done cycle
    localparam int W      = 53;                  // {done cycle, sad, idx}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sad_min_tracker_if bus();

    sad_min_tracker #(
        .LEAD_CYCLES  (LEAD),
        .PIX_PER_CAND (PPC),
        .NUM_PAIRS    (NPAIR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_pushed = 0;

    logic [7:0] c_a  [NPIX];
    logic [7:0] p_a  [NPIX];
    logic [7:0] pp_a [NPIX];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Straight from the definition: SAD of every candidate, then the
    // first candidate holding the smallest SAD.
    function automatic logic [W-1:0] model(input int unsigned done_cyc);
        int best;
        int bidx;
        best = 1 << 30;
        bidx = 0;
        for (int cand = 0; cand < NCAND; cand++) begin
            int s;
            int pair;
            s = 0;
            pair = cand / 2;
            for (int i = 0; i < PPC; i++) begin
                int pix;
                int r;
                int d;
                pix = pair * PPC + i;
                r = (cand % 2 == 1) ? int'(pp_a[pix]) : int'(p_a[pix]);
                d = r - int'(c_a[pix]);
                s += (d < 0) ? -d : d;
            end
            if (s < best) begin
                best = s;
                bidx = cand;
            end
        end
        return {32'(done_cyc), 16'(best), 5'(bidx)};
    endfunction

    // ---------------- stimulus generation ----------------
    task automatic gen(input int mode);
        for (int pix = 0; pix < NPIX; pix++) begin
            int k;
            int cv;
            k = pix / PPC;
            cv = int'($urandom_range(1, 254));
            case (mode)
                0: begin c_a[pix] = 8'h10; p_a[pix] = 8'h10; pp_a[pix] = 8'h11; end
                1: begin
                    c_a[pix]  = 8'(cv);
                    p_a[pix]  = 8'(cv + 1);
                    pp_a[pix] = (k == 7) ? 8'(cv) : 8'(cv - 1);
                end
                2: begin c_a[pix] = 8'(cv); p_a[pix] = 8'(cv + 1); pp_a[pix] = 8'(cv - 1); end
                3: begin c_a[pix] = 8'h00; p_a[pix] = 8'hFF; pp_a[pix] = 8'hFF; end
                4: begin
                    c_a[pix]  = 8'($urandom_range(0, 255));
                    p_a[pix]  = 8'($urandom_range(0, 255));
                    pp_a[pix] = 8'($urandom_range(0, 255));
                end
                default: begin
                    // near-identical candidates: small SADs, frequent ties
                    c_a[pix]  = 8'(cv);
                    p_a[pix]  = 8'(cv) ^ 8'($urandom_range(0, 1));
                    pp_a[pix] = 8'(cv) ^ 8'($urandom_range(0, 1));
                end
            endcase
        end
    endtask

    task automatic drive_garbage();
        bus.c       = 8'($urandom_range(0, 255));
        bus.p       = 8'($urandom_range(0, 255));
        bus.p_prime = 8'($urandom_range(0, 255));
    endtask

    // ---------------- driver ----------------
    // abort_at / reset_at >= 0 cut the search short at that pixel index.
    task automatic run_search(input int mode, input int abort_at, input int reset_at);
        int unsigned s;
        gen(mode);
        @(negedge clk);
        bus.start = 1'b1;
        drive_garbage();
        s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        drive_garbage();
        chk("busy_rise", 32'(bus.busy), 32'd1);
        repeat (LEAD - 1) begin
            @(negedge clk);
            drive_garbage();
        end
        for (int j = 0; j < NPIX; j++) begin
            @(negedge clk);
            if (j == abort_at) return;
            if (j == reset_at) begin
                reset = 1'b0;
                @(negedge clk);
                chk("reset_busy", 32'(bus.busy), 32'd0);
                chk("reset_done", 32'(bus.done), 32'd0);
                chk("reset_best_sad", 32'(bus.best_sad), 32'd0);
                chk("reset_best_idx", 32'(bus.best_idx), 32'd0);
                chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
                reset = 1'b1;
                return;
            end
            bus.c       = c_a[j];
            bus.p       = p_a[j];
            bus.p_prime = pp_a[j];
        end
        exp_q.push_back(model(s + DONE_LAT));
        n_pushed++;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_e;
    always @(negedge clk) begin
        if (reset && bus.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e[52:21]);
                chk("best_sad", 32'(bus.best_sad), 32'(mon_e[20:5]));
                chk("best_idx", 32'(bus.best_idx), 32'(mon_e[4:0]));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.start   = 1'b0;
        bus.c       = '0;
        bus.p       = '0;
        bus.p_prime = '0;
        repeat (3) @(negedge clk);
        chk("init_busy", 32'(bus.busy), 32'd0);
        chk("init_done", 32'(bus.done), 32'd0);
        chk("init_best_sad", 32'(bus.best_sad), 32'd0);
        chk("init_best_idx", 32'(bus.best_idx), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_search(0, -1, -1);     // zero SAD on candidate 0
        run_search(1, -1, -1);     // back-to-back: odd winner in pair 7
        run_search(2, -1, -1);     // all ties at 256
        repeat (3) @(negedge clk);
        run_search(3, -1, -1);     // maximum SAD 65280
        run_search(4, 2000, -1);   // aborted by a restart
        run_search(5, -1, -1);     // the restart itself
        run_search(4, -1, 1000);   // reset mid-search
        repeat (2) @(negedge clk);
        run_search(4, -1, -1);     // normal search after reset

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
